// File: rtl/scc_mem_dump_checker_pkg.sv
// Shared types and constants for the post-halt memory dump checker.
// Imported by the checker FSM and its timeout counter.
package scc_dump_pkg;

  typedef enum logic [2:0] {
    WAIT_HALT = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DATA = 3'd2,
    EMIT      = 3'd3,
    FINISH    = 3'd4,
    DONE      = 3'd5
  } dump_state_e;

  localparam int unsigned WORD_BYTES         = 32'd4;
  localparam logic [1:0]  ERR_NONE           = 2'b00;
  localparam logic [31:0] KADANE_RESULT_ADDR = 32'h0000_0500;
  localparam logic [31:0] KADANE_EXPECTED    = 32'h0000_0037;

  // Final verdict: any timeout, core error, missing or wrong watched word fails.
  function automatic logic dump_verdict(input logic timed_out, input logic found,
                                        input logic match, input logic [1:0] err);
    return !timed_out && found && match && (err == ERR_NONE);
  endfunction

endpackage

// File: rtl/scc_mem_dump_checker_if.sv
// Read port towards data memory plus the valid/ready beat stream towards the dump writer.
// master = checker side, slave = memory/dump-writer side.
interface scc_mem_dump_checker_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output mem_rd_en, mem_addr, dump_valid, dump_addr, dump_data,
    input  mem_rdata, dump_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, dump_valid, dump_addr, dump_data,
    output mem_rdata, dump_ready
  );
endinterface

// File: rtl/scc_mem_dump_checker_timeout.sv
// Enabled-cycle counter that flags the cycle in which the halt wait budget is used up.
// TIMEOUT_CYCLES = 0 disables the flag entirely.
module scc_dump_timeout
  import scc_dump_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic terminal
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_term_s;

  // terminal is seen while the TIMEOUT_CYCLES-th enabled cycle is in progress
  assign at_term_s = (TIMEOUT_CYCLES != 32'd0) && (count_q == TERM_VAL);
  assign terminal  = at_term_s;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !at_term_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scc_mem_dump_checker.sv
// Post-halt checker: walks a word-aligned memory window, streams (addr, data) beats,
// and checks one watched word against an expected value.
module scc_mem_dump_checker
  import scc_dump_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic                   halt_f,
  input  logic [1:0]             err_bits,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic [ADDR_W-1:0]      end_addr,
  input  logic [ADDR_W-1:0]      watch_addr,
  input  logic [DATA_W-1:0]      expected_value,
  scc_mem_dump_checker_if.master bus,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 32'd1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, end_q, end_d, watch_q, watch_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [1:0]        err_q, err_d;
  logic              halt_q, halt_d, found_q, found_d, match_q, match_d;
  logic              mem_rd_en_q, mem_rd_en_d, dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
  logic              tmo_term_s;
  logic [ADDR_W-1:0] start_al_s, end_al_s;

  assign start_al_s = start_addr & ALIGN_MASK;
  assign end_al_s   = end_addr & ALIGN_MASK;

  scc_dump_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en && (state_q == WAIT_HALT)),
    .clr      (clk_en && (state_q != WAIT_HALT)),
    .terminal (tmo_term_s)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    end_d        = end_q;
    watch_d      = watch_q;
    exp_d        = exp_q;
    err_d        = err_q;
    halt_d       = halt_q;
    found_d      = found_q;
    match_d      = match_q;
    mem_rd_en_d  = mem_rd_en_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    if (clk_en) begin
      case (state_q)
        WAIT_HALT: begin
          // halt beats timeout when both land in the same cycle
          if (halt_f || halt_q) begin
            halt_d  = 1'b1;
            err_d   = halt_q ? err_q : err_bits;
            cur_d   = start_al_s;
            end_d   = end_al_s;
            watch_d = watch_addr & ALIGN_MASK;
            exp_d   = expected_value;
            if (end_al_s < start_al_s) begin
              state_d = FINISH;
            end else begin
              state_d     = ISSUE;
              mem_rd_en_d = 1'b1;
            end
          end else if (tmo_term_s) begin
            timeout_d = 1'b1;
            state_d   = FINISH;
          end else begin
            state_d = WAIT_HALT;
          end
        end
        ISSUE: begin
          mem_rd_en_d = 1'b0;
          state_d     = WAIT_DATA;
        end
        WAIT_DATA: begin
          dump_data_d  = bus.mem_rdata;
          dump_addr_d  = cur_q;
          dump_valid_d = 1'b1;
          if (cur_q == watch_q) begin
            found_d = 1'b1;
            match_d = (bus.mem_rdata == exp_q);
          end else begin
            found_d = found_q;
          end
          state_d = EMIT;
        end
        EMIT: begin
          // equality test before the increment keeps a window ending at the top word from wrapping
          if (bus.dump_ready) begin
            dump_valid_d = 1'b0;
            if (cur_q == end_q) begin
              state_d = FINISH;
            end else begin
              cur_d       = cur_q + STEP;
              mem_rd_en_d = 1'b1;
              state_d     = ISSUE;
            end
          end else begin
            state_d = EMIT;
          end
        end
        FINISH: begin
          pass_d  = dump_verdict(timeout_q, found_q, match_q, err_q);
          fail_d  = !dump_verdict(timeout_q, found_q, match_q, err_q);
          done_d  = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = WAIT_HALT;
        end
      endcase
    end else if ((state_q == WAIT_HALT) && halt_f && !halt_q) begin
      // a halt pulse during a stalled cycle is remembered rather than lost
      halt_d = 1'b1;
      err_d  = err_bits;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_HALT;
      cur_q        <= '0;
      end_q        <= '0;
      watch_q      <= '0;
      exp_q        <= '0;
      err_q        <= ERR_NONE;
      halt_q       <= 1'b0;
      found_q      <= 1'b0;
      match_q      <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      watch_q      <= watch_d;
      exp_q        <= exp_d;
      err_q        <= err_d;
      halt_q       <= halt_d;
      found_q      <= found_d;
      match_q      <= match_d;
      mem_rd_en_q  <= mem_rd_en_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.mem_rd_en  = mem_rd_en_q & clk_en;
  assign bus.mem_addr   = cur_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_data  = dump_data_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = timeout_q;

endmodule
